// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch datapath: default rates, field moduli and field widths.
package stopwatch_pkg;

   localparam int unsigned CLK_FREQ_DEF = 100_000_000;
   localparam int unsigned TICK_HZ_DEF  = 100;

   localparam int unsigned MSEC_MAX_DEF = 100;
   localparam int unsigned SEC_MAX_DEF  = 60;
   localparam int unsigned MIN_MAX_DEF  = 60;
   localparam int unsigned HOUR_MAX_DEF = 24;

   localparam int unsigned MSEC_W = 7;
   localparam int unsigned SEC_W  = 6;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned HOUR_W = 5;

   // Counter width for a modulus, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/time_counter.sv
// Wrap-around field counter; o_carry flags the tick that wraps it so stages can be chained.
module time_counter #(
   parameter int unsigned MAX   = 60,
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_tick,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_carry
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

   logic [WIDTH-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (i_clear) begin
         cnt_reg <= '0;
      end else if (i_tick) begin
         cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + WIDTH'(1);
      end
   end

   assign o_cnt   = cnt_reg;
   assign o_carry = i_tick & (cnt_reg == LAST);

endmodule

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: 100 Hz prescaler plus a msec/sec/min/hour counter cascade.
module stopwatch_dp
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
   parameter int unsigned TICK_HZ  = TICK_HZ_DEF,
   parameter int unsigned MSEC_MAX = MSEC_MAX_DEF,
   parameter int unsigned SEC_MAX  = SEC_MAX_DEF,
   parameter int unsigned MIN_MAX  = MIN_MAX_DEF,
   parameter int unsigned HOUR_MAX = HOUR_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_runstop,
   input  logic              i_clear,
   output logic [MSEC_W-1:0] o_msec,
   output logic [SEC_W-1:0]  o_sec,
   output logic [MIN_W-1:0]  o_min,
   output logic [HOUR_W-1:0] o_hour,
   output logic              o_tick
);

   localparam int unsigned       DIV      = CLK_FREQ / TICK_HZ;
   localparam int unsigned       DIV_W    = cnt_width(DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_cnt_reg;
   logic             tick_reg;

   // Pausing holds div_cnt so the sub-tick phase survives a stop/start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_reg <= '0;
         tick_reg    <= 1'b0;
      end else if (i_clear) begin
         div_cnt_reg <= '0;
         tick_reg    <= 1'b0;
      end else if (i_runstop) begin
         if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b1;
         end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            tick_reg    <= 1'b0;
         end
      end else begin
         tick_reg <= 1'b0;
      end
   end

   logic msec_carry;
   logic sec_carry;
   logic min_carry;
   logic unused_hour_carry;

   // Counters consume tick_reg regardless of run, so a tick raised on the last run cycle still lands.
   time_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
      .clk     (clk),
      .reset   (reset),
      .i_tick  (tick_reg),
      .i_clear (i_clear),
      .o_cnt   (o_msec),
      .o_carry (msec_carry)
   );

   time_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
      .clk     (clk),
      .reset   (reset),
      .i_tick  (msec_carry),
      .i_clear (i_clear),
      .o_cnt   (o_sec),
      .o_carry (sec_carry)
   );

   time_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
      .clk     (clk),
      .reset   (reset),
      .i_tick  (sec_carry),
      .i_clear (i_clear),
      .o_cnt   (o_min),
      .o_carry (min_carry)
   );

   time_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
      .clk     (clk),
      .reset   (reset),
      .i_tick  (min_carry),
      .i_clear (i_clear),
      .o_cnt   (o_hour),
      .o_carry (unused_hour_carry)
   );

   assign o_tick = tick_reg;

endmodule

// File: tb/tb_stopwatch_dp.sv
// Randomised and directed bench for stopwatch_dp against a total-tick-count reference model.
module tb_stopwatch_dp;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic run = 1'b0, clr = 1'b0;
   logic s_run = 1'b0, s_clr = 1'b0;

   logic [6:0] o_msec, s_msec;
   logic [5:0] o_sec, s_sec, o_min, s_min;
   logic [4:0] o_hour, s_hour;
   logic       o_tick, s_tick;

   int total_cnt = 0;
   int bad_cnt   = 0;

   always #5 clk = ~clk;

   // Main instance: DIV = 10, default moduli.
   stopwatch_dp #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
      .clk(clk), .reset(reset), .i_runstop(run), .i_clear(clr),
      .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_tick(o_tick)
   );

   // Small instance: DIV = 2 and tiny moduli so a full-day wrap is reachable quickly.
   stopwatch_dp #(.CLK_FREQ(2), .TICK_HZ(1), .MSEC_MAX(4), .SEC_MAX(3), .MIN_MAX(3), .HOUR_MAX(2)) dut_s (
      .clk(clk), .reset(reset), .i_runstop(s_run), .i_clear(s_clr),
      .o_msec(s_msec), .o_sec(s_sec), .o_min(s_min), .o_hour(s_hour), .o_tick(s_tick)
   );

   wire logic [24:0] act_main  = {o_hour, o_min, o_sec, o_msec, o_tick};
   wire logic [24:0] act_small = {s_hour, s_min, s_sec, s_msec, s_tick};

   // Model: sub-tick phase, pending tick, and total ticks consumed since zero.
   typedef struct packed {
      int     phase;
      logic   pend;
      longint total;
   } mdl_t;

   mdl_t m_main  = '0;
   mdl_t m_small = '0;

   function automatic mdl_t mstep(input mdl_t mi, input logic rst_n, input logic r,
                                  input logic c, input int div);
      mdl_t mo = mi;
      if (!rst_n || c) begin
         mo = '0;
      end else begin
         if (mi.pend) mo.total = mi.total + 1;
         if (r) begin
            mo.pend  = (mi.phase == div - 1);
            mo.phase = (mi.phase == div - 1) ? 0 : mi.phase + 1;
         end else begin
            mo.pend = 1'b0;
         end
      end
      return mo;
   endfunction

   function automatic logic [24:0] expv(input mdl_t m, input int m0, input int m1,
                                        input int m2, input int m3);
      logic [24:0] v;
      longint t = m.total;
      v[0]     = m.pend;
      v[7:1]   = 7'(t % m0);
      v[13:8]  = 6'((t / m0) % m1);
      v[19:14] = 6'((t / (m0 * m1)) % m2);
      v[24:20] = 5'((t / (m0 * m1 * m2)) % m3);
      return v;
   endfunction

   task automatic cycle();
      @(posedge clk);
      m_main  = mstep(m_main, reset, run, clr, 10);
      m_small = mstep(m_small, reset, s_run, s_clr, 2);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; run = 1'b1; clr = 1'b0;
      repeat (5) begin
         cycle();
         total_cnt++;
         if (act_main !== 25'd0) begin
            bad_cnt++;
            $display("FAIL reset_hold act=%h exp=0", act_main);
         end
      end
      reset = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         cycle();
         total_cnt++;
         if (act_main !== expv(m_main, 100, 60, 60, 24)) begin
            bad_cnt++;
            $display("FAIL reset_release edge=%0d act=%h exp=%h", e, act_main, expv(m_main, 100, 60, 60, 24));
         end
         if (e == 10 || e == 11) begin
            total_cnt++;
            if (o_msec !== ((e == 11) ? 7'd1 : 7'd0)) begin
               bad_cnt++;
               $display("FAIL first_msec edge=%0d act=%0d exp=%0d", e, o_msec, (e == 11) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_run_1000();
      int ticks = 0;
      clr = 1'b1; cycle(); clr = 1'b0; run = 1'b1;
      for (int c = 1; c <= 1000; c++) begin
         cycle();
         total_cnt++;
         if (act_main !== expv(m_main, 100, 60, 60, 24)) begin
            bad_cnt++;
            $display("FAIL run1000 cyc=%0d act=%h exp=%h", c, act_main, expv(m_main, 100, 60, 60, 24));
         end
         if (o_tick === 1'b1) begin
            ticks++;
            total_cnt++;
            if (c % 10 != 0) begin
               bad_cnt++;
               $display("FAIL tick_phase cyc=%0d act=1 exp=0", c);
            end
         end
      end
      run = 1'b0;
      cycle();
      total_cnt++;
      if (ticks != 100) begin
         bad_cnt++;
         $display("FAIL tick_count act=%0d exp=100", ticks);
      end
      total_cnt++;
      if ({o_hour, o_min, o_sec, o_msec} !== {5'd0, 6'd0, 6'd1, 7'd0}) begin
         bad_cnt++;
         $display("FAIL run1000_final act=%0d:%0d:%0d.%0d exp=0:0:1.0", o_hour, o_min, o_sec, o_msec);
      end
   endtask

   task automatic test_pause();
      clr = 1'b1; run = 1'b0; cycle(); clr = 1'b0;
      run = 1'b1;
      repeat (34) cycle();
      total_cnt++;
      if (o_msec !== 7'd3) begin
         bad_cnt++;
         $display("FAIL pause_entry act=%0d exp=3", o_msec);
      end
      run = 1'b0;
      for (int c = 0; c < 50; c++) begin
         cycle();
         total_cnt++;
         if (o_msec !== 7'd3 || o_tick !== 1'b0) begin
            bad_cnt++;
            $display("FAIL pause_hold cyc=%0d act=%0d/%0b exp=3/0", c, o_msec, o_tick);
         end
      end
      run = 1'b1;
      repeat (6) cycle();
      total_cnt++;
      if (o_msec !== 7'd3 || o_tick !== 1'b1) begin
         bad_cnt++;
         $display("FAIL resume_tick act=%0d/%0b exp=3/1", o_msec, o_tick);
      end
      run = 1'b0;
      cycle();
      total_cnt++;
      if (o_msec !== 7'd4) begin
         bad_cnt++;
         $display("FAIL resume_msec act=%0d exp=4", o_msec);
      end
   endtask

   task automatic test_clear_on_tick();
      int guard = 0;
      clr = 1'b1; cycle(); clr = 1'b0; run = 1'b1;
      while (!(m_main.total == 57 && m_main.pend) && guard < 2000) begin
         cycle();
         guard++;
      end
      total_cnt++;
      if (guard >= 2000 || o_msec !== 7'd57 || o_tick !== 1'b1) begin
         bad_cnt++;
         $display("FAIL clear_setup act=%0d/%0b exp=57/1 guard=%0d", o_msec, o_tick, guard);
      end
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      total_cnt++;
      if (act_main !== 25'd0) begin
         bad_cnt++;
         $display("FAIL clear_on_tick act=%h exp=0", act_main);
      end
      for (int e = 1; e <= 11; e++) begin
         cycle();
         total_cnt++;
         if (o_tick !== ((e == 10) ? 1'b1 : 1'b0) || act_main !== expv(m_main, 100, 60, 60, 24)) begin
            bad_cnt++;
            $display("FAIL clear_restart edge=%0d act=%h exp=%h", e, act_main, expv(m_main, 100, 60, 60, 24));
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         run   = ($urandom_range(0, 3) != 0);
         clr   = ($urandom_range(0, 59) == 0);
         s_run = ($urandom_range(0, 3) != 0);
         s_clr = ($urandom_range(0, 79) == 0);
         cycle();
         total_cnt++;
         if (act_main !== expv(m_main, 100, 60, 60, 24) || act_small !== expv(m_small, 4, 3, 3, 2)) begin
            bad_cnt++;
            $display("FAIL random cyc=%0d act=%h/%h exp=%h/%h", c, act_main, act_small,
                     expv(m_main, 100, 60, 60, 24), expv(m_small, 4, 3, 3, 2));
         end
         total_cnt++;
         if (o_msec >= 100 || o_sec >= 60 || o_min >= 60 || o_hour >= 24) begin
            bad_cnt++;
            $display("FAIL random_bounds act=%0d:%0d:%0d.%0d exp=in_range", o_hour, o_min, o_sec, o_msec);
         end
      end
      run = 1'b0; clr = 1'b0; s_run = 1'b0; s_clr = 1'b0;
   endtask

   task automatic test_wrap();
      int          wraps = 0;
      logic [24:0] prev;
      s_clr = 1'b1; cycle(); s_clr = 1'b0; s_run = 1'b1;
      for (int c = 0; c < 160; c++) begin
         prev = act_small;
         cycle();
         total_cnt++;
         if (act_small !== expv(m_small, 4, 3, 3, 2) || s_msec >= 4 || s_sec >= 3 || s_min >= 3 || s_hour >= 2) begin
            bad_cnt++;
            $display("FAIL wrap_track cyc=%0d act=%h exp=%h", c, act_small, expv(m_small, 4, 3, 3, 2));
         end
         if (prev === {5'd1, 6'd2, 6'd2, 7'd3, 1'b1}) begin
            wraps++;
            total_cnt++;
            if ({s_hour, s_min, s_sec, s_msec} !== 24'd0) begin
               bad_cnt++;
               $display("FAIL day_wrap act=%0d:%0d:%0d.%0d exp=0:0:0.0", s_hour, s_min, s_sec, s_msec);
            end
         end
      end
      total_cnt++;
      if (wraps != 1) begin
         bad_cnt++;
         $display("FAIL day_wrap_count act=%0d exp=1", wraps);
      end
      s_run = 1'b0;
   endtask

   task automatic test_async_reset();
      int guard = 0;
      clr = 1'b1; cycle(); clr = 1'b0; run = 1'b1;
      while (m_main.total != 1234 && guard < 20000) begin
         cycle();
         guard++;
      end
      total_cnt++;
      if (guard >= 20000 || {o_hour, o_min, o_sec, o_msec} !== {5'd0, 6'd0, 6'd12, 7'd34}) begin
         bad_cnt++;
         $display("FAIL async_setup act=%0d:%0d:%0d.%0d exp=0:0:12.34", o_hour, o_min, o_sec, o_msec);
      end
      #2;
      reset = 1'b0;
      #1;
      m_main = '0;
      m_small = '0;
      total_cnt++;
      if (act_main !== 25'd0 || act_small !== 25'd0) begin
         bad_cnt++;
         $display("FAIL async_reset act=%h/%h exp=0/0", act_main, act_small);
      end
      repeat (2) cycle();
      reset = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         cycle();
         total_cnt++;
         if (act_main !== expv(m_main, 100, 60, 60, 24)) begin
            bad_cnt++;
            $display("FAIL async_resume edge=%0d act=%h exp=%h", e, act_main, expv(m_main, 100, 60, 60, 24));
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_1000();
      test_pause();
      test_clear_on_tick();
      test_random();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/stopwatch_dp.md
Name: stopwatch_dp

Overview:
- Datapath stage directly downstream of the stopwatch control FSM.
- Consumes its level outputs `run` (count enable) and `clear` (synchronous zero).
- Produces the hour/min/sec/centisecond time fields that the FND display path formats.
- Contains a prescaler generating a 100 Hz tick from the system clock, and a cascade of four wrap-around counters.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, base count rate in Hz; DIV = CLK_FREQ/TICK_HZ, must divide exactly and be >= 2.
- MSEC_MAX, 100, centisecond field modulus.
- SEC_MAX, 60, seconds field modulus.
- MIN_MAX, 60, minutes field modulus.
- HOUR_MAX, 24, hours field modulus.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- i_runstop  input  1  level from control FSM; 1 = counting enabled.
- i_clear  input  1  level from control FSM; 1 = hold everything at zero.
- o_msec  output  7  centiseconds 0..MSEC_MAX-1.
- o_sec  output  6  seconds 0..SEC_MAX-1.
- o_min  output  6  minutes 0..MIN_MAX-1.
- o_hour  output  5  hours 0..HOUR_MAX-1.
- o_tick  output  1  registered one-cycle 100 Hz tick, for debug/bench.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0): divider count, tick register and all four fields go to 0 immediately, independent of clk. All outputs read 0 while reset is low.
- Prescaler `div_cnt`, width clog2(DIV):
  - i_clear=1: div_cnt <= 0 and tick_reg <= 0. Clear has priority over run.
  - i_runstop=1 and div_cnt==DIV-1: div_cnt <= 0, tick_reg <= 1.
  - i_runstop=1 otherwise: div_cnt <= div_cnt+1, tick_reg <= 0.
  - i_runstop=0: div_cnt holds, so the sub-tick phase is preserved across pause/resume; tick_reg <= 0.
- Latency: starting from div_cnt=0, the first tick_reg=1 is seen after DIV edges with i_runstop=1. o_msec increments on the next edge, i.e. edge DIV+1.
- A tick registered on the last run cycle is still consumed after i_runstop falls. No tick is ever lost or duplicated.
- Counter cascade, evaluated on edges where tick_reg=1 and i_clear=0:
  - msec <= (msec==MSEC_MAX-1) ? 0 : msec+1.
  - sec advances only when msec wraps.
  - min advances only when sec and msec both wrap.
  - hour advances only when min, sec and msec all wrap.
  - hour wraps 23 -> 0, so 23:59:59.99 -> 00:00:00.00 in one edge.
- i_clear=1 on any edge: all fields <= 0, overriding a coincident tick.
- i_clear and i_runstop both 1 (not produced by the FSM, but defined): clear wins.
- Fields never exceed modulus-1. Unused high bits are 0.
- Outputs are registered directly, with no combinational path from inputs to outputs.
- Reset asserted mid-count: asynchronous zeroing. After release, counting resumes from 0 only while i_runstop=1.

Decomposition:
- Shared package `stopwatch_pkg`:
  - Default moduli (100/60/60/24).
  - Field widths (7/6/6/5).
  - Default CLK_FREQ/TICK_HZ.
- One natural sub-module, `time_counter`:
  - Parameters: MAX, WIDTH.
  - Inputs: clk, reset, i_tick, i_clear.
  - Outputs: o_cnt, o_carry. o_carry = i_tick & (cnt==MAX-1), combinational.
  - Instantiated four times in a chain, each stage's i_tick driven by the previous stage's o_carry.
  - The prescaler stays inline in stopwatch_dp.

Test Plan (bench uses CLK_FREQ=1000, TICK_HZ=100, so DIV=10):
- Reset low with i_runstop=1 for 5 cycles, then release -> all outputs 0 during reset; o_msec=1 exactly 11 edges after release.
- i_runstop=1 for 1000 clk cycles from zero -> o_tick pulses every 10 cycles; final o_msec=0, o_sec=1, all other fields 0.
- Run 34 cycles, pause 50 cycles, resume 6 cycles -> o_msec=3 during the pause; o_msec=4 one edge after the resume's 6th cycle (phase kept); no change while paused.
- Preload by running to 23:59:59.99 (or force via cascade at TICK_HZ=CLK_FREQ/2), then one more tick -> all fields 0 on the same edge; no field exceeds its modulus at any point.
- i_clear=1 on the same edge tick_reg=1 at msec=57 -> all fields 0, o_tick=0 next cycle, div_cnt restarts from 0.
- Assert reset low mid-count at 00:00:12.34 -> outputs 0 asynchronously, before the next clk edge.
